// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement scheduler: FSM state codes,
// channel-width helper and elaboration-time parameter sanity checks.
package freq_meas_pkg;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETTLE = 3'd1;
   localparam state_t ST_CLEAR  = 3'd2;
   localparam state_t ST_GATE   = 3'd3;
   localparam state_t ST_WAIT   = 3'd4;
   localparam state_t ST_REPORT = 3'd5;

   function automatic int ch_width(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // The phase timer is loaded with N-1, but it must be able to represent the largest phase length.
   function automatic bit params_ok(input int num_ch, input int ch_w, input int cntr_size,
                                    input int gate_cycles, input int settle_cycles,
                                    input int cdc_lat, input int timer_w);
      longint max_len;
      max_len = longint'(max3(gate_cycles, settle_cycles, cdc_lat));
      return (num_ch >= 2) && (num_ch <= 16) && (ch_w == ch_width(num_ch)) &&
             (cntr_size >= 1) && (gate_cycles >= 1) && (settle_cycles >= 1) &&
             (cdc_lat >= 1) && (timer_w >= 1) && (timer_w <= 32) &&
             (max_len <= ((longint'(1) << timer_w) - 1));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// (last_i + 1) mod NUM_CH.
module rr_arbiter
   import freq_meas_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   last_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [CH_W-1:0]   grant_idx_o,
   output logic              any_req_o
);

   logic found;
   int   k;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      k           = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         // last_i never exceeds NUM_CH-1, so two conditional subtractions wrap any offset.
         k = int'(last_i) + 1 + i;
         if (k >= NUM_CH) k = k - NUM_CH;
         if (k >= NUM_CH) k = k - NUM_CH;
         if (!found && req_i[k]) begin
            found       = 1'b1;
            grant_o[k]  = 1'b1;
            grant_idx_o = CH_W'(k);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/freq_meas_scheduler.sv
// Time-shares one freq_counter between NUM_CH clock sources: arbitrate, settle,
// clear, gate, wait out CDC latency, then hand the tagged count to the host.
module freq_meas_scheduler
   import freq_meas_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int CH_W          = ch_width(NUM_CH),
   parameter int CNTR_SIZE     = 10,
   parameter int GATE_CYCLES   = 1000,
   parameter int SETTLE_CYCLES = 4,
   parameter int CDC_LAT       = 3,
   parameter int TIMER_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [NUM_CH-1:0]    req_i,
   output logic [CH_W-1:0]      sel_o,
   output logic                 cntr_clr_o,
   output logic                 gate_o,
   input  logic [CNTR_SIZE-1:0] cnt_in_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [CH_W-1:0]      res_chan_o,
   output logic [CNTR_SIZE-1:0] res_freq_o,
   output logic                 res_sat_o,
   output logic                 busy_o,
   output state_t               state_o,
   output logic [NUM_CH-1:0]    arb_grant_o
);

   if (!params_ok(NUM_CH, CH_W, CNTR_SIZE, GATE_CYCLES, SETTLE_CYCLES, CDC_LAT, TIMER_W))
   begin : g_bad_params
      $error("freq_meas_scheduler: parameter out of range");
   end

   localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GATE_LD   = TIMER_W'(GATE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] WAIT_LD   = TIMER_W'(CDC_LAT - 1);
   localparam logic [CH_W-1:0]    LAST_RST  = CH_W'(NUM_CH - 1);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [CH_W-1:0]      sel_q, sel_d;
   logic [CH_W-1:0]      last_q, last_d;
   logic [CH_W-1:0]      chan_q, chan_d;
   logic [CNTR_SIZE-1:0] freq_q, freq_d;
   logic                 sat_q, sat_d;
   logic                 clr_q, gate_q, valid_q, busy_q;

   logic [NUM_CH-1:0]    grant_oh;
   logic [CH_W-1:0]      grant_idx;
   logic                 any_req;
   logic                 timer_done;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req_i       (req_i),
      .last_i      (last_q),
      .grant_o     (grant_oh),
      .grant_idx_o (grant_idx),
      .any_req_o   (any_req)
   );

   assign timer_done = (timer_q == '0);

   // Handshake: a result is transferred on any cycle where res_valid_o && res_ready_i;
   // res_chan_o/res_freq_o/res_sat_o are held stable while valid is high and ready is low.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      sel_d   = sel_q;
      last_d  = last_q;
      chan_d  = chan_q;
      freq_d  = freq_q;
      sat_d   = sat_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i && any_req) begin
               sel_d   = grant_idx;
               timer_d = SETTLE_LD;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!en_i)           state_d = ST_IDLE;
            else if (timer_done) state_d = ST_CLEAR;
            else                 timer_d = timer_q - TIMER_W'(1);
         end
         ST_CLEAR: begin
            if (!en_i) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = GATE_LD;
               state_d = ST_GATE;
            end
         end
         ST_GATE: begin
            if (!en_i) begin
               state_d = ST_IDLE;
            end else if (timer_done) begin
               timer_d = WAIT_LD;
               state_d = ST_WAIT;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_WAIT: begin
            if (!en_i) begin
               state_d = ST_IDLE;
            end else if (timer_done) begin
               chan_d  = sel_q;
               freq_d  = cnt_in_i;
               sat_d   = (cnt_in_i == {CNTR_SIZE{1'b1}});
               state_d = ST_REPORT;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_REPORT: begin
            // en_i is deliberately ignored here so a captured result is never dropped.
            if (res_ready_i) begin
               last_d  = chan_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         sel_q   <= '0;
         last_q  <= LAST_RST;
         chan_q  <= '0;
         freq_q  <= '0;
         sat_q   <= 1'b0;
         clr_q   <= 1'b0;
         gate_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         chan_q  <= chan_d;
         freq_q  <= freq_d;
         sat_q   <= sat_d;
         clr_q   <= (state_d == ST_CLEAR);
         gate_q  <= (state_d == ST_GATE);
         valid_q <= (state_d == ST_REPORT);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign sel_o       = sel_q;
   assign cntr_clr_o  = clr_q;
   assign gate_o      = gate_q;
   assign res_valid_o = valid_q;
   assign res_chan_o  = chan_q;
   assign res_freq_o  = freq_q;
   assign res_sat_o   = sat_q;
   assign busy_o      = busy_q;
   assign state_o     = state_q;
   assign arb_grant_o = grant_oh;

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
- Single-clock controller that shares one `freq_counter` datapath between NUM_CH measured clock sources.
- Round-robin arbitration picks a requesting channel and drives the external input mux select.
- It then sequences settle, counter clear, a fixed-length reference gate window and a wait for the CDC latency, before capturing the count.
- The result is returned over a valid/ready handshake, tagged with its channel.
- Sits between the measurement input mux + `freq_counter` and the register/host interface.

Parameters:
- NUM_CH, 4, number of measured channels (2..16).
- CH_W, $clog2(NUM_CH), channel index width (derived).
- CNTR_SIZE, 10, width of the count result (matches counter).
- GATE_CYCLES, 1000, gate window length in clk cycles (>=1).
- SETTLE_CYCLES, 4, cycles after a mux change before clearing (>=1).
- CDC_LAT, 3, cycles from gate close until cnt_in is valid (>=1).
- TIMER_W, 16, phase timer width; must hold max(GATE_CYCLES, SETTLE_CYCLES, CDC_LAT).

Ports:
- clk  in  1  reference clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scheduler enable.
- req  in  NUM_CH  per-channel measurement request (level).
- sel  out  CH_W  input mux select to the counter.
- cntr_clr  out  1  one-cycle counter clear pulse.
- gate  out  1  counting window to the counter.
- cnt_in  in  CNTR_SIZE  count from the counter, already in clk domain.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_chan  out  CH_W  channel of the result.
- res_freq  out  CNTR_SIZE  captured count.
- res_sat  out  1  cnt_in was all-ones (possible overflow).
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered (Moore, decoded from next-state).
- Reset values: sel=0, cntr_clr=0, gate=0, res_valid=0, res_chan=0, res_freq=0, res_sat=0, busy=0, state=IDLE, rr pointer such that ch0 has top priority.
- States: IDLE, SETTLE, CLEAR, GATE, WAIT, REPORT.
- IDLE: if en && |req, grant the first requesting channel at or after (last_served+1) mod NUM_CH.
  - Granted index goes to sel; go to SETTLE with timer loaded.
  - Otherwise stay in IDLE; sel holds its last value.
- SETTLE: exactly SETTLE_CYCLES cycles, then CLEAR.
- CLEAR: cntr_clr=1 for exactly 1 cycle, then GATE.
- GATE: gate=1 for exactly GATE_CYCLES consecutive cycles, then WAIT.
- WAIT: exactly CDC_LAT cycles. On the last WAIT cycle, capture res_freq<=cnt_in, res_chan<=sel, res_sat<=(cnt_in=={CNTR_SIZE{1'b1}}). Then REPORT.
- REPORT: res_valid=1; res_freq/res_chan/res_sat held stable while valid && !ready.
  - On valid&&ready: res_valid drops next cycle, last_served<=res_chan, state goes to IDLE.
  - A new grant happens on the IDLE cycle at the earliest, so there is one idle bubble between measurements.
- Latency: from the grant cycle to res_valid rising = SETTLE_CYCLES + 1 + GATE_CYCLES + CDC_LAT + 1 cycles.
- Req rules:
  - A grant is sticky: dropping req of the granted channel mid-measurement does not abort it.
  - Requests are not queued; a channel must still be requesting when IDLE arbitrates.
- en deasserted in SETTLE/CLEAR/GATE/WAIT aborts:
  - next cycle state=IDLE, gate=0, cntr_clr=0, no result produced, last_served unchanged.
- en deasserted in REPORT: no effect; the pending result is still delivered.
- Single requester: the same channel is re-granted every round.
- All requesters: strict rotation 0,1,2,...,NUM_CH-1,0.
- The rr pointer wraps from NUM_CH-1 to 0.
- Reset asserted mid-operation returns everything to reset values immediately (async). A pending result is lost.
- Timer counts down from N-1 to 0; the phase ends on timer==0. No arithmetic overflow is possible given the TIMER_W rule.

Decomposition:
- Package freq_meas_pkg:
  - state enum (IDLE, SETTLE, CLEAR, GATE, WAIT, REPORT);
  - helper function computing CH_W;
  - elaboration-time parameter range checks.
- Sub-module rr_arbiter:
  - inputs: req vector and last_served;
  - outputs: one-hot grant, grant index and any_req;
  - purely combinational.
- The FSM, timer and result registers live in freq_meas_scheduler.

Test Plan:
Bench parameters: NUM_CH=4, GATE_CYCLES=8, SETTLE_CYCLES=2, CDC_LAT=3, CNTR_SIZE=10, res_ready tied high unless stated.
1. Single request, req=4'b0100, cnt_in model=10'd57 -> sel=2; cntr_clr pulses once; gate high for exactly 8 cycles; res_valid rises 15 cycles after the grant with res_chan=2, res_freq=57, res_sat=0.
2. req=4'b1111 held -> results in channel order 0,1,2,3,0; each result separated by at least one IDLE cycle.
3. Backpressure: res_ready=0 for 20 cycles after res_valid -> res_valid/res_freq/res_chan stay constant; no new gate pulse; one cycle after ready=1, valid=0.
4. en dropped on GATE cycle 4 -> gate low the next cycle; state IDLE; no res_valid. Re-enable with req=4'b0001 -> fresh full measurement of ch0.
5. cnt_in=10'h3FF at capture -> res_sat=1 and res_freq=1023. Granted req dropped during SETTLE -> result still produced.
6. rst asserted (low) asynchronously mid-WAIT -> all outputs go to reset values without waiting for a clk edge. After release with req=4'b0010 -> ch1 granted.
